syscall_input_unit: RTL and testbench

- Input-side counterpart of the syscall print path: services console-read syscalls (v0=5 read_int, v0=8 read_string, v0=12 read_char) from a host byte stream.
- Buffers host bytes in a small FIFO.
- Holds the CPU with a stall while servicing.
- Writes strings into data memory one byte per cycle and returns integers/chars for writeback to $v0.

---
 rtl/syscall_input_unit.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_syscall_input_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/syscall_input_unit.sv
// Console-read syscall service unit: buffers host bytes and services
// read_int (5), read_string (8) and read_char (12) while stalling the CPU.
module syscall_input_unit #(
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_STR    = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        syscall_en,
  input  logic [31:0] v0,
  input  logic [31:0] a0,
  input  logic [31:0] a1,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        stall,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        v0_we,
  output logic [31:0] v0_wdata,
  output logic        done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]  FIFO_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [31:0]  STR_LIMIT = 32'(MAX_STR - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_STR      = 3'd1,
    S_STR_TERM = 3'd2,
    S_INT      = 3'd3,
    S_CHAR     = 3'd4,
    S_FINISH   = 3'd5
  } state_e;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= 8'h30) && (b <= 8'h39);
  endfunction

  function automatic logic is_blank(input logic [7:0] b);
    return (b == 8'h20) || (b == 8'h09);
  endfunction

  function automatic logic is_svc_code(input logic [31:0] code);
    return (code == 32'd5) || (code == 32'd8) || (code == 32'd12);
  endfunction

  // ---------------- host byte FIFO ----------------
  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          in_ready_q, in_ready_d;
  logic          push_s, pop_s, empty_s;
  logic [7:0]    head_s;

  assign push_s  = in_valid && in_ready_q;
  assign empty_s = (count_q == '0);
  assign head_s  = fifo_q[rd_ptr_q];

  // FIFO pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    in_ready_d = (count_d != FIFO_FULL);
  end

  // FIFO control registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
    end
  end

  // FIFO storage; contents are meaningless while count is zero
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_q[wr_ptr_q] <= in_data;
    end
  end

  assign in_ready = in_ready_q;

  // ---------------- syscall FSM ----------------
  state_e      state_q, state_d;
  logic [31:0] ptr_q, ptr_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] acc_q, acc_d;
  logic        neg_q, neg_d;
  logic        seen_q, seen_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic        v0_we_q, v0_we_d;
  logic [31:0] v0_wdata_q, v0_wdata_d;
  logic        done_q, done_d;
  logic        stall_s;

  // Next-state, datapath and registered-output selection
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    neg_d       = neg_q;
    seen_d      = seen_q;
    pop_s       = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = 32'd0;
    mem_wdata_d = 8'd0;
    v0_we_d     = 1'b0;
    v0_wdata_d  = 32'd0;
    stall_s     = 1'b1;
    case (state_q)
      S_IDLE: begin
        stall_s = syscall_en && is_svc_code(v0);
        if (syscall_en) begin
          case (v0)
            32'd8: begin
              ptr_d = a0;
              rem_d = a1 - 32'd1;
              cnt_d = 32'd0;
              if (a1[31] || (a1 == 32'd0)) begin
                state_d = S_FINISH;
              end else if (a1 == 32'd1) begin
                state_d = S_STR_TERM;
              end else begin
                state_d = S_STR;
              end
            end
            32'd5: begin
              acc_d   = 32'd0;
              neg_d   = 1'b0;
              seen_d  = 1'b0;
              state_d = S_INT;
            end
            32'd12:  state_d = S_CHAR;
            default: state_d = S_IDLE;
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_STR: begin
        if (!empty_s) begin
          pop_s       = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = ptr_q;
          mem_wdata_d = head_s;
          ptr_d       = ptr_q + 32'd1;
          rem_d       = rem_q - 32'd1;
          cnt_d       = cnt_q + 32'd1;
          // rem_q==1 means this byte exhausts the caller's room before the terminator
          if ((head_s == 8'h0A) || (rem_q == 32'd1) || ((cnt_q + 32'd1) == STR_LIMIT)) begin
            state_d = S_STR_TERM;
          end else begin
            state_d = S_STR;
          end
        end else begin
          state_d = S_STR;
        end
      end
      S_STR_TERM: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = ptr_q;
        mem_wdata_d = 8'h00;
        state_d     = S_FINISH;
      end
      S_INT: begin
        if (!empty_s) begin
          pop_s = 1'b1;
          if (is_blank(head_s) && !seen_q) begin
            state_d = S_INT;
          end else if ((head_s == 8'h2D) && !seen_q) begin
            neg_d   = 1'b1;
            seen_d  = 1'b1;
            state_d = S_INT;
          end else if (is_digit(head_s)) begin
            acc_d   = (acc_q * 32'd10) + {28'd0, head_s[3:0]};
            seen_d  = 1'b1;
            state_d = S_INT;
          end else begin
            v0_we_d    = 1'b1;
            v0_wdata_d = neg_q ? (32'd0 - acc_q) : acc_q;
            state_d    = S_FINISH;
          end
        end else begin
          state_d = S_INT;
        end
      end
      S_CHAR: begin
        if (!empty_s) begin
          pop_s      = 1'b1;
          v0_we_d    = 1'b1;
          v0_wdata_d = {24'd0, head_s};
          state_d    = S_FINISH;
        end else begin
          state_d = S_CHAR;
        end
      end
      S_FINISH: begin
        // PC advances here, so a syscall_en seen now belongs to no pending request
        stall_s = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        stall_s = 1'b0;
        state_d = S_IDLE;
      end
    endcase
    done_d = (state_d == S_FINISH);
  end

  // FSM state, datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ptr_q       <= 32'd0;
      rem_q       <= 32'd0;
      cnt_q       <= 32'd0;
      acc_q       <= 32'd0;
      neg_q       <= 1'b0;
      seen_q      <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 8'd0;
      v0_we_q     <= 1'b0;
      v0_wdata_q  <= 32'd0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      neg_q       <= neg_d;
      seen_q      <= seen_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      v0_we_q     <= v0_we_d;
      v0_wdata_q  <= v0_wdata_d;
      done_q      <= done_d;
    end
  end

  assign stall     = stall_s;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign v0_we     = v0_we_q;
  assign v0_wdata  = v0_wdata_q;
  assign done      = done_q;

endmodule

// File: tb/tb_syscall_input_unit.sv
// Scoreboard bench for syscall_input_unit: expected memory and $v0 writes
// are queued when a syscall is issued and compared as the DUT emits them.
module tb_syscall_input_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        syscall_en;
  logic [31:0] v0, a0, a1;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready, stall, mem_we, v0_we, done;
  logic [31:0] mem_addr, v0_wdata;
  logic [7:0]  mem_wdata;

  int n_vec = 0;
  int n_err = 0;
  logic [39:0] exp_mem_q [$];
  logic [31:0] exp_v0_q  [$];

  syscall_input_unit #(.FIFO_DEPTH(16), .MAX_STR(256)) dut (
    .clk(clk), .reset(reset), .syscall_en(syscall_en), .v0(v0), .a0(a0), .a1(a1),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .stall(stall),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .v0_we(v0_we), .v0_wdata(v0_wdata), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // output monitor: every write strobe must match the head of its queue
  always @(negedge clk) begin
    logic [39:0] e;
    if (mem_we && v0_we) chk("write_exclusive", {31'd0, v0_we}, 32'd0);
    if (mem_we) begin
      if (exp_mem_q.size() == 0) begin
        chk("mem_unexpected", {31'd0, mem_we}, 32'd0);
      end else begin
        e = exp_mem_q.pop_front();
        chk("mem_addr", mem_addr, e[39:8]);
        chk("mem_wdata", {24'd0, mem_wdata}, {24'd0, e[7:0]});
      end
    end
    if (v0_we) begin
      if (exp_v0_q.size() == 0) chk("v0_unexpected", {31'd0, v0_we}, 32'd0);
      else chk("v0_wdata", v0_wdata, exp_v0_q.pop_front());
    end
  end

  task automatic push_byte(input logic [7:0] b);
    logic r;
    int t;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = b;
    r = 1'b0;
    t = 0;
    while (!r && t < 100) begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk); #1;
      t++;
    end
    if (!r) chk("push_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) push_byte(s[i]);
  endtask

  task automatic do_syscall(input logic [31:0] code, input logic [31:0] addr,
                            input logic [31:0] len, input logic exp_stall);
    @(posedge clk); #1;
    syscall_en = 1'b1;
    v0 = code;
    a0 = addr;
    a1 = len;
    @(negedge clk);
    chk("stall_on_issue", {31'd0, stall}, {31'd0, exp_stall});
    @(posedge clk); #1;
    syscall_en = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!done) chk("stall_busy", {31'd0, stall}, 32'd1);
    end while (!done && lat < 300);
    if (!done) chk("done_timeout", 32'd0, 32'd1);
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("stall_released", {31'd0, stall}, 32'd0);
  endtask

  initial begin
    int lat;
    int acc;
    int n;
    reset = 1'b1; syscall_en = 1'b0; v0 = 32'd0; a0 = 32'd0; a1 = 32'd0;
    in_valid = 1'b0; in_data = 8'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_v0_we", {31'd0, v0_we}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_v0_wdata", v0_wdata, 32'd0);

    // unsupported code: no stall, no completion
    do_syscall(32'd1, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    chk("bad_code_stall", {31'd0, stall}, 32'd0);
    chk("bad_code_done", {31'd0, done}, 32'd0);

    // read_string "hi\n" into 0x100
    push_str("hi\n");
    exp_mem_q.push_back({32'h100, 8'h68});
    exp_mem_q.push_back({32'h101, 8'h69});
    exp_mem_q.push_back({32'h102, 8'h0A});
    exp_mem_q.push_back({32'h103, 8'h00});
    do_syscall(32'd8, 32'h100, 32'd10, 1'b1);
    wait_done(lat);
    chk("str_done_latency", lat, 32'd5);

    // read_string truncated by n=4, leftover bytes read as chars
    push_str("abcdef");
    exp_mem_q.push_back({32'h300, 8'h61});
    exp_mem_q.push_back({32'h301, 8'h62});
    exp_mem_q.push_back({32'h302, 8'h63});
    exp_mem_q.push_back({32'h303, 8'h00});
    do_syscall(32'd8, 32'h300, 32'd4, 1'b1);
    wait_done(lat);
    for (int i = 0; i < 3; i++) begin
      exp_v0_q.push_back(32'h64 + i);
      do_syscall(32'd12, 32'd0, 32'd0, 1'b1);
      wait_done(lat);
    end

    // n=1 writes only the terminator
    exp_mem_q.push_back({32'h380, 8'h00});
    do_syscall(32'd8, 32'h380, 32'd1, 1'b1);
    wait_done(lat);

    // read_int with leading blanks and sign
    push_str("  -123\n");
    exp_v0_q.push_back(32'hFFFFFF85);
    do_syscall(32'd5, 32'd0, 32'd0, 1'b1);
    wait_done(lat);

    // read_int on an empty FIFO stalls until input arrives
    exp_v0_q.push_back(32'd7);
    do_syscall(32'd5, 32'd0, 32'd0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("int_wait_stall", {31'd0, stall}, 32'd1);
    end
    push_str("7\n");
    wait_done(lat);

    // empty line reads as zero
    push_str("\n");
    exp_v0_q.push_back(32'd0);
    do_syscall(32'd5, 32'd0, 32'd0, 1'b1);
    wait_done(lat);

    // FIFO fill: 17 bytes offered back to back, only 16 fit
    @(posedge clk); #1;
    acc = 0;
    in_valid = 1'b1;
    in_data  = 8'h41;
    for (int i = 0; i < 30; i++) begin
      logic r;
      @(negedge clk);
      r = in_ready;
      @(posedge clk); #1;
      if (r) begin
        acc++;
        in_data = 8'(8'h41 + acc);
      end
    end
    chk("fill_accepted", acc, 32'd16);
    @(negedge clk);
    chk("fill_in_ready", {31'd0, in_ready}, 32'd0);
    exp_v0_q.push_back(32'h41);
    do_syscall(32'd12, 32'd0, 32'd0, 1'b1);
    wait_done(lat);
    in_valid = 1'b0;
    for (int i = 1; i < 17; i++) begin
      exp_v0_q.push_back(32'h41 + i);
      do_syscall(32'd12, 32'd0, 32'd0, 1'b1);
      wait_done(lat);
    end

    // reset in the middle of a read_string
    push_str("abcdef");
    exp_mem_q.push_back({32'h200, 8'h61});
    exp_mem_q.push_back({32'h201, 8'h62});
    do_syscall(32'd8, 32'h200, 32'd10, 1'b1);
    n = 0;
    for (int i = 0; i < 50 && n < 2; i++) begin
      @(negedge clk);
      if (mem_we) n++;
    end
    chk("writes_before_reset", n, 32'd2);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_stall", {31'd0, stall}, 32'd0);
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("post_rst_mem_we", {31'd0, mem_we}, 32'd0);
    repeat (5) @(negedge clk);
    do_syscall(32'd8, 32'h400, 32'd0, 1'b1);
    wait_done(lat);
    push_str("Z");
    exp_v0_q.push_back(32'h5A);
    do_syscall(32'd12, 32'd0, 32'd0, 1'b1);
    wait_done(lat);

    repeat (3) @(negedge clk);
    chk("mem_queue_drained", exp_mem_q.size(), 32'd0);
    chk("v0_queue_drained", exp_v0_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
